// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives the PLL reset, synchronizes and qualifies the
// PLL lock flag, and releases the system reset once lock has been stable.
// Lock timeouts are retried a bounded number of times before a sticky FAIL.
module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 7,
   parameter int unsigned CNT_W         = 17
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       lock_fail,
   output logic [3:0] retry_count,
   output logic [2:0] state
);

   localparam logic [2:0] S_RESET_PLL = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAIL      = 3'd4;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

   logic             r_locked_meta;
   logic             r_locked_s;
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_retry;

   logic [2:0]       w_state_d;
   logic [CNT_W-1:0] w_cnt_d;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [3:0]       w_retry_d;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // Two-flop synchronizer for the asynchronous lock flag.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_locked_meta <= 1'b0;
         r_locked_s    <= 1'b0;
      end else begin
         r_locked_meta <= locked;
         r_locked_s    <= r_locked_meta;
      end
   end

   // Next-state logic; the shared counter restarts at zero on every state change.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_retry_d = r_retry;
      unique case (r_state)
         S_RESET_PLL: begin
            if (r_cnt == RST_LAST) begin
               w_state_d = S_WAIT_LOCK;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         S_WAIT_LOCK: begin
            if (r_locked_s) begin
               w_state_d = S_STABLE;
               w_cnt_d   = '0;
            end else if (r_cnt == TIMEOUT_LAST && r_retry == RETRY_MAX) begin
               w_state_d = S_FAIL;
               w_cnt_d   = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_state_d = S_RESET_PLL;
               w_cnt_d   = '0;
               w_retry_d = r_retry + 4'd1;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         S_STABLE: begin
            // A drop here is treated as a glitch: retry count kept, timeout restarts.
            if (!r_locked_s) begin
               w_state_d = S_WAIT_LOCK;
               w_cnt_d   = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_state_d = S_RUN;
               w_cnt_d   = '0;
               w_retry_d = 4'd0;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         S_RUN: begin
            w_cnt_d = '0;
            if (!r_locked_s) begin
               w_state_d = S_RESET_PLL;
            end
         end
         S_FAIL: begin
            w_cnt_d = '0;
         end
         default: begin
            w_state_d = S_RESET_PLL;
            w_cnt_d   = '0;
            w_retry_d = 4'd0;
         end
      endcase
      // Software relock overrides every other transition.
      if (relock_req) begin
         w_state_d = S_RESET_PLL;
         w_cnt_d   = '0;
         w_retry_d = 4'd0;
      end
   end

   // State, counter and retry registers.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state <= S_RESET_PLL;
         r_cnt   <= '0;
         r_retry <= 4'd0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_retry <= w_retry_d;
      end
   end

   // Moore output decode of the registered state.
   always_comb begin
      pll_rst     = (r_state == S_RESET_PLL) || (r_state == S_FAIL);
      sys_rst     = (r_state != S_RUN);
      ready       = (r_state == S_RUN);
      lock_fail   = (r_state == S_FAIL);
      retry_count = r_retry;
      state       = r_state;
   end

endmodule
